cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: arbitrates N_REQ result producers onto one common data bus with a one-cycle broadcast pipeline
// Ports: clk, reset (async, active-high); req_valid/req_ready request/grant per producer;
//   req_tag (ROB tag, valid in request cycle); req_data (result, valid the cycle after grant);
//   cdb {valid, tag, data} broadcast; grant_count saturating 16-bit grant counter.
// Config: define CDB_ARB_RR_EN for round-robin priority; otherwise lowest index wins.
package cdb_pkg;
  parameter int ROB_WIDTH = 6;
  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag,
  input  logic [N_REQ-1:0][31:0]          req_data,
  output cdb_t                            cdb,
  output logic [15:0]                     grant_count
);
  localparam int PW = $clog2(N_REQ);
  logic                 r_vld;
  logic [ROB_WIDTH-1:0] r_tag;
  logic [PW-1:0]        r_idx;
  logic [15:0]          r_cnt;
  logic [PW-1:0]        w_base, w_idx, w_cand;
  logic [PW:0]          w_sum;
  logic                 w_found;
`ifdef CDB_ARB_RR_EN
  logic [PW-1:0] r_rr_ptr;
  assign w_base = r_rr_ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_rr_ptr <= '0;
    else if (w_found) r_rr_ptr <= (w_idx == PW'(N_REQ-1)) ? '0 : w_idx + 1'b1;
`else
  assign w_base = '0;
`endif
  // Scan from the highest offset down so the requester closest to w_base is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      w_sum  = {1'b0, w_base} + (PW+1)'(k);
      w_cand = (w_sum >= (PW+1)'(N_REQ)) ? PW'(w_sum - (PW+1)'(N_REQ)) : PW'(w_sum);
      if (req_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end
  assign req_ready = (w_found && !reset) ? (N_REQ'(1) << w_idx) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_vld <= 1'b0;
      r_tag <= '0;
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      r_vld <= w_found;
      if (w_found) begin
        r_tag <= req_tag[w_idx];
        r_idx <= w_idx;
        r_cnt <= &r_cnt ? r_cnt : r_cnt + 16'd1;
      end
    end
  // Producers register their result, so data is picked up one cycle after the grant.
  assign cdb         = {r_vld, r_tag, req_data[r_idx]};
  assign grant_count = r_cnt;
endmodule
